// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter (8 data bits, 1 stop bit) with a small byte FIFO in front.
// Bytes are queued through a valid/ready handshake. The serial engine pops the
// head byte and sends start, data (LSB first), optional parity and stop. If
// another byte is waiting, the next frame follows with no idle gap.
//
// Optional feature:
//   UART_TX_PARITY_EN : when defined, an even-parity bit (XOR of the 8 data
//                       bits) is sent between the last data bit and the stop
//                       bit, giving an 11-bit frame. Otherwise frames are 10
//                       bits.
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per serial bit (>= 2)
//   FIFO_DEPTH   : queued bytes, power of two in 2..16
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   tx_data    in   byte offered for transmission
//   tx_valid   in   tx_data holds a byte
//   tx_ready   out  FIFO can accept a byte this cycle
//   tx         out  registered serial line, idle high
//   busy       out  frame on the line or FIFO non-empty
//   fifo_count out  number of queued bytes
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Serial engine
  state_e        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;

  logic push;
  logic pop;
  logic bit_last;

  // Readiness uses the registered count only, so a pop in the same cycle
  // never makes room for a push; held low while reset is asserted.
  assign tx_ready   = !rst && (count_q < CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign bit_last   = (bit_cnt_q == BW'(CLKS_PER_BIT - 1));

  assign tx         = tx_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop       = 1'b1;
          data_d    = mem[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = START;
          tx_d      = 1'b0;
        end
      end

      START: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
          tx_d      = data_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end

      DATA: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^data_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = data_q[bit_idx_q + 3'd1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          state_d   = STOP;
          tx_d      = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
`endif

      STOP: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          // Chain straight into the next frame when a byte is waiting.
          if (count_q != '0) begin
            pop     = 1'b1;
            data_d  = mem[rd_ptr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only read
  // after being written, and count/pointers already define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A behavioural model keeps a queue of pending bytes and the edge at which
// the current frame started. tx is predicted from the frame bit list, and
// tx_ready, busy and fifo_count are checked every cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       active = 1'b0;
  int         start_e = 0;
  logic [7:0] cur = 8'h00;
  int         e = 0;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Bit idx of a frame: 0 start, 1..8 data LSB first, optional parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic exp_line();
    if (!active) return 1'b1;
    return frame_bit(cur, (e - start_e) / CPB);
  endfunction

  // One clock cycle: drive at negedge, check ready before the edge, advance
  // the model at the edge, check the registered outputs at the next negedge.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d,
                       input string tag);
    int   pre;
    logic exp_ready;
    logic exp_tx;
    logic exp_busy;
    logic [2:0] exp_cnt;
    rst      = r;
    tx_valid = v;
    tx_data  = d;
    #1;
    exp_ready = !r && (q.size() < DEPTH);
    total++;
    if (tx_ready !== exp_ready) begin
      bad++;
      $display("FAIL %s tx_ready: got %b want %b (edge %0d)", tag, tx_ready, exp_ready, e);
    end
    @(posedge clk);
    e++;
    if (r) begin
      q.delete();
      active = 1'b0;
    end else begin
      pre = q.size();
      if (active && e >= start_e + FRAME) active = 1'b0;
      if (!active && pre > 0) begin
        cur     = q.pop_front();
        start_e = e;
        active  = 1'b1;
      end
      if (v && pre < DEPTH) q.push_back(d);
    end
    @(negedge clk);
    exp_tx   = exp_line();
    exp_busy = active || (q.size() != 0);
    exp_cnt  = 3'(q.size());
    total++;
    if (tx !== exp_tx) begin
      bad++;
      $display("FAIL %s tx: got %b want %b (edge %0d)", tag, tx, exp_tx, e);
    end
    total++;
    if (busy !== exp_busy) begin
      bad++;
      $display("FAIL %s busy: got %b want %b (edge %0d)", tag, busy, exp_busy, e);
    end
    total++;
    if (fifo_count !== exp_cnt) begin
      bad++;
      $display("FAIL %s fifo_count: got %0d want %0d (edge %0d)", tag, fifo_count, exp_cnt, e);
    end
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) cycle(1'b0, 1'b0, 8'h00, tag);
  endtask

  // Reset with random pushes attempted while reset is high (must be dropped).
  task automatic test_reset();
    repeat (3) cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), "reset");
    idle(2, "reset_release");
  endtask

  task automatic test_single();
    cycle(1'b0, 1'b1, 8'hA5, "single_a5");
    idle(FRAME + 4, "single_a5");
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b1, 8'h13, "b2b_fixed");
    cycle(1'b0, 1'b1, 8'h37, "b2b_fixed");
    cycle(1'b0, 1'b1, 8'h00, "b2b_fixed");
    idle(3 * FRAME + 4, "b2b_fixed");
    repeat (3) cycle(1'b0, 1'b1, 8'($urandom), "b2b_rand");
    idle(3 * FRAME + 4, "b2b_rand");
  endtask

  task automatic test_full();
    repeat (6) cycle(1'b0, 1'b1, 8'($urandom), "full");
    idle(6 * FRAME + 4, "full_drain");
  endtask

  task automatic test_reset_midframe();
    cycle(1'b0, 1'b1, 8'hFF, "midreset");
    cycle(1'b0, 1'b1, 8'($urandom), "midreset");
    cycle(1'b0, 1'b1, 8'($urandom), "midreset");
    idle(3 * CPB, "midreset_data");
    cycle(1'b1, 1'b0, 8'h00, "midreset_rst");
    idle(FRAME + 4, "midreset_after");
  endtask

  task automatic test_parity_bytes();
    cycle(1'b0, 1'b1, 8'h07, "parity_07");
    idle(FRAME + 2, "parity_07");
    cycle(1'b0, 1'b1, 8'h03, "parity_03");
    idle(FRAME + 2, "parity_03");
  endtask

  task automatic test_random();
    repeat (400) cycle(1'b0, 1'($urandom_range(0, 5) == 0), 8'($urandom), "random");
    idle(6 * FRAME + 4, "random_drain");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_midframe();
    test_parity_bytes();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
